// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  BLANK_SEG  = 8'hFF;
  localparam logic [7:0]  AN_OFF     = 8'hFF;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/tick_div.sv
// Free-running prescaler: counts 0..DIV-1 while enabled and flags the last count.
module tick_div #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick_c = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed seven-segment driver with frame-coherent shadow capture
// and optional whole-panel blinking.
module seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [7:0] segs_i [NUM_DIGITS-1:0],
  input  logic       blink_i,
  output logic [7:0] seg_o,
  output logic [7:0] an_o,
  output logic       frame_o
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned FW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FW-1:0]    FCNT_LAST = FW'(BLINK_DIV - 1);

  scan_state_e      state, next_state;
  logic [7:0]       shadow [NUM_DIGITS-1:0];
  logic [IDX_W-1:0] idx;
  logic [FW-1:0]    fcnt;
  logic             phase;
  logic             tick_c;
  logic             scan_c;
  logic             frame_c;

  assign scan_c  = (state == SCAN) && en_i;
  assign frame_c = scan_c && tick_c && (idx == IDX_LAST);

  tick_div #(.DIV(CLK_DIV)) u_div (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (state != SCAN),
    .en     (scan_c),
    .tick_c (tick_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= OFF;
    else       state <= next_state;
  end

  // Disable wins over any scan event in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      OFF:     if (en_i) next_state = LOAD;
      LOAD:    next_state = SCAN;
      SCAN:    if (!en_i) next_state = OFF;
      default: next_state = OFF;
    endcase
  end

  // Shadow, digit index and blink phase; shadow only refreshes between frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow <= '{default: BLANK_SEG};
      idx    <= '0;
      fcnt   <= '0;
      phase  <= 1'b0;
    end else begin
      if (state == OFF) begin
        idx   <= '0;
        fcnt  <= '0;
        phase <= 1'b0;
      end
      if (state == LOAD) begin
        shadow <= segs_i;
        idx    <= '0;
      end
      if (scan_c && tick_c) idx <= idx + IDX_W'(1);
      if (frame_c) begin
        shadow <= segs_i;
        if (fcnt == FCNT_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end

  // Blanking only masks segments; digit enables keep scanning.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o    <= AN_OFF;
      seg_o   <= BLANK_SEG;
      frame_o <= 1'b0;
    end else begin
      frame_o <= frame_c;
      if (state == SCAN) begin
        an_o  <= ~(8'(1) << idx);
        seg_o <= (blink_i && phase) ? BLANK_SEG : shadow[idx];
      end else begin
        an_o  <= AN_OFF;
        seg_o <= BLANK_SEG;
      end
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner at three dwell/blink configurations.
module tb_seg_scanner;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, blink;
  logic [7:0] segs [7:0];
  logic [7:0] seg_a, an_a, seg_b, an_b, seg_c, an_c;
  logic       frm_a, frm_b, frm_c;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_scanner #(.CLK_DIV(4), .BLINK_DIV(64)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .segs_i(segs), .blink_i(blink),
    .seg_o(seg_a), .an_o(an_a), .frame_o(frm_a));

  seg_scanner #(.CLK_DIV(2), .BLINK_DIV(2)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .segs_i(segs), .blink_i(blink),
    .seg_o(seg_b), .an_o(an_b), .frame_o(frm_b));

  seg_scanner #(.CLK_DIV(1), .BLINK_DIV(64)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .segs_i(segs), .blink_i(blink),
    .seg_o(seg_c), .an_o(an_c), .frame_o(frm_c));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    en    = 1'b0;
    blink = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seg;
    logic       exp_frm;
    logic       bl;

    for (int k = 0; k < 8; k++) segs[k] = 8'(32'h10 + k);
    do_reset();
    check("rst_an_a", an_a, 8'hFF);
    check("rst_seg_a", seg_a, 8'hFF);
    check("rst_frm_a", 8'(frm_a), 8'h00);
    check("rst_an_b", an_b, 8'hFF);
    check("rst_an_c", an_c, 8'hFF);

    // Enable, scan, mid-frame update and disable on the frame boundary
    en = 1'b1;
    step();
    check("off_an", an_a, 8'hFF);
    step();
    check("load_an", an_a, 8'hFF);
    check("load_seg", seg_a, 8'hFF);
    for (int f = 0; f < 4; f++) begin
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 4; c++) begin
          step();
          exp_seg = (d == 5 && f >= 2) ? 8'hAA : 8'(32'h10 + d);
          exp_frm = (d == 7 && c == 3 && f < 3);
          check($sformatf("a_an f%0d d%0d c%0d", f, d, c), an_a, ~(8'(1) << d));
          check($sformatf("a_seg f%0d d%0d c%0d", f, d, c), seg_a, exp_seg);
          check($sformatf("a_frm f%0d d%0d c%0d", f, d, c), 8'(frm_a), 8'(exp_frm));
          if (f == 1 && d == 2 && c == 1) segs[5] = 8'hAA;
          if (f == 3 && d == 7 && c == 2) begin
            en      = 1'b0;
            segs[5] = 8'h55;
          end
        end
      end
    end
    step();
    check("dis_an", an_a, 8'hFF);
    check("dis_seg", seg_a, 8'hFF);
    check("dis_frm", 8'(frm_a), 8'h00);

    // Re-enable goes through LOAD and restarts at digit 0 with a fresh snapshot
    en = 1'b1;
    step();
    check("re_off_an", an_a, 8'hFF);
    step();
    check("re_load_an", an_a, 8'hFF);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp_seg = (d == 5) ? 8'h55 : 8'(32'h10 + d);
        check($sformatf("re_an d%0d c%0d", d, c), an_a, ~(8'(1) << d));
        check($sformatf("re_seg d%0d c%0d", d, c), seg_a, exp_seg);
        check($sformatf("re_frm d%0d c%0d", d, c), 8'(frm_a), 8'(d == 7 && c == 3));
      end
    end

    // Reset asserted while idx is 4
    for (int d = 0; d < 5; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(d == 4 && c > 1)) begin
          step();
          check($sformatf("pre_rst_an d%0d c%0d", d, c), an_a, ~(8'(1) << d));
        end
      end
    end
    rst = 1'b1;
    step();
    check("mrst_an", an_a, 8'hFF);
    check("mrst_seg", seg_a, 8'hFF);
    check("mrst_frm", 8'(frm_a), 8'h00);
    check("mrst_state", 8'(u_a.state), 8'(OFF));
    rst = 1'b0;
    step();
    check("mrst_off_an", an_a, 8'hFF);
    step();
    check("mrst_load_an", an_a, 8'hFF);
    step();
    check("mrst_first_an", an_a, 8'hFE);
    check("mrst_first_seg", seg_a, 8'h10);

    // Blinking with CLK_DIV=2, BLINK_DIV=2
    do_reset();
    segs[5] = 8'h15;
    blink   = 1'b1;
    bl      = 1'b1;
    en      = 1'b1;
    step();
    step();
    check("b_load_an", an_b, 8'hFF);
    for (int f = 0; f < 4; f++) begin
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 2; c++) begin
          step();
          exp_seg = (bl && ((f / 2) % 2 == 1)) ? 8'hFF : 8'(32'h10 + d);
          check($sformatf("b_an f%0d d%0d c%0d", f, d, c), an_b, ~(8'(1) << d));
          check($sformatf("b_seg f%0d d%0d c%0d", f, d, c), seg_b, exp_seg);
          if (f == 3 && d == 3 && c == 0) begin
            blink = 1'b0;
            bl    = 1'b0;
          end
        end
      end
    end

    // Single-cycle dwell
    do_reset();
    en = 1'b1;
    step();
    step();
    check("c_load_an", an_c, 8'hFF);
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 8; d++) begin
        step();
        check($sformatf("c_an f%0d d%0d", f, d), an_c, ~(8'(1) << d));
        check($sformatf("c_seg f%0d d%0d", f, d), seg_c, 8'(32'h10 + d));
        check($sformatf("c_frm f%0d d%0d", f, d), 8'(frm_c), 8'(d == 7));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
